seq_right_shifter: RTL and testbench

Multi-cycle right shifter for the accumulator datapath. It is the counterpart to the single-step left shift: it shifts an operand right by a programmable amount, one bit per clock, in logical or arithmetic mode. It reports the last bit shifted out as a carry. It sits beside the ALU, and the control unit drives it through a start/busy/done handshake.

---
 rtl/seq_right_shifter.sv | 78 +++++++
 tb/tb_seq_right_shifter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/seq_right_shifter.sv
// Multi-cycle right shifter: shifts an operand right one bit per clock,
// logical or arithmetic, and reports the last bit shifted out as a carry.
module seq_right_shifter #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [AMT_W-1:0] amt,
    input  logic             arith,
    output logic [WIDTH-1:0] R,
    output logic             C,
    output logic             busy,
    output logic             done
);

    // state | meaning
    // IDLE  | waiting for start; R/C hold the last result
    // SHIFT | one bit per clock until cnt reaches zero, then publish
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] data;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            data  <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            mode  <= 1'b0;
            R     <= '0;
            C     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        data  <= A;
                        // Amounts of WIDTH or more all produce a full fill, so clamp.
                        cnt   <= (int'(amt) >= WIDTH) ? CNT_W'(WIDTH) : CNT_W'(amt);
                        carry <= 1'b0;
                        mode  <= arith;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        carry <= data[0];
                        data  <= {mode & data[WIDTH-1], data[WIDTH-1:1]};
                        cnt   <= cnt - CNT_W'(1);
                    end else begin
                        R     <= data;
                        C     <= carry;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_right_shifter.sv
// Self-checking bench for seq_right_shifter: directed cases plus random
// operations compared against an arithmetic shift model.
module tb_seq_right_shifter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] A;
    logic [4:0]  amt;
    logic        arith;
    logic [15:0] R;
    logic        C;
    logic        busy;
    logic        done;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [15:0] prev_r   = '0;
    logic        prev_c   = 1'b0;

    seq_right_shifter #(.WIDTH(16), .AMT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .amt(amt), .arith(arith),
        .R(R), .C(C), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [15:0] a, input int am, input bit ar,
                                  output logic [15:0] r, output logic c, output int k);
        k = (am > 16) ? 16 : am;
        if (ar) r = $signed(a) >>> k;
        else    r = a >> k;
        c = (k == 0) ? 1'b0 : a[k-1];
    endfunction

    // Called at posedge+1; start is raised in this cycle (cycle N).
    task automatic run_op(input logic [15:0] a, input int am, input bit ar, input bit poke);
        logic [15:0] er;
        logic        ec;
        int          k;
        int          cyc;
        bit          got;
        model(a, am, ar, er, ec, k);
        start = 1'b1; A = a; amt = 5'(am); arith = ar;
        @(posedge clk); #1;
        start = 1'b0; A = 16'($urandom); amt = 5'($urandom); arith = 1'($urandom);
        cyc = 1;
        got = 0;
        while (cyc <= 40 && !got) begin
            if (done === 1'b1) begin
                got = 1;
            end else begin
                check("busy_during_op", 32'(busy), 32'd1);
                check("R_hold", 32'(R), 32'(prev_r));
                check("C_hold", 32'(C), 32'(prev_c));
                if (poke && cyc == 2) begin
                    start = 1'b1; A = 16'h00F0; amt = 5'd8; arith = 1'b0;
                end
                if (poke && cyc == 3) start = 1'b0;
                @(posedge clk); #1;
                cyc++;
            end
        end
        if (!got) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            check("latency", 32'(cyc), 32'(k + 2));
            check("R", 32'(R), 32'(er));
            check("C", 32'(C), 32'(ec));
            check("busy_at_done", 32'(busy), 32'd0);
            prev_r = er;
            prev_c = ec;
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; A = '0; amt = '0; arith = 1'b0;
        #3;
        check("rst_R", 32'(R), 32'd0);
        check("rst_C", 32'(C), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(16'hB5A3, 4, 1'b0, 1'b0);
        check("dir_logical_R", 32'(R), 32'h0B5A);
        @(posedge clk); #1;
        check("done_pulse_end", 32'(done), 32'd0);
        run_op(16'h8004, 3, 1'b1, 1'b0);
        check("dir_arith_R", 32'(R), 32'hF000);
        check("dir_arith_C", 32'(C), 32'd1);
        @(posedge clk); #1;
        run_op(16'h1234, 0, 1'b0, 1'b0);
        @(posedge clk); #1;
        run_op(16'hFFFF, 20, 1'b0, 1'b0);
        check("dir_clamp_C", 32'(C), 32'd1);
        @(posedge clk); #1;
        run_op(16'hF00F, 6, 1'b1, 1'b1);
        run_op(16'h0003, 1, 1'b0, 1'b0);
        check("b2b_R", 32'(R), 32'h0001);

        // Asynchronous reset with no clock edge
        rst_n = 1'b0;
        #2;
        check("async_rst_R", 32'(R), 32'd0);
        check("async_rst_C", 32'(C), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        prev_r = '0; prev_c = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of a shift
        start = 1'b1; A = 16'hFFFF; amt = 5'd10; arith = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("midop_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midop_busy", 32'(busy), 32'd0);
        check("midop_R", 32'(R), 32'd0);
        check("midop_C", 32'(C), 32'd0);
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            if (i == 2) rst_n = 1'b1;
            check("midop_no_done", 32'(done), 32'd0);
        end
        run_op(16'hC3A5, 5, 1'b1, 1'b0);

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
                check("rand_done_pulse_end", 32'(done), 32'd0);
            end
            run_op(16'($urandom), int'($urandom_range(0, 31)), 1'($urandom), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
